mem_arbiter: RTL
================

# mem_arbiter

Shares one unified memory port between the CPU's instruction-fetch requester and its data-memory (MEM stage) requester. Sits between the cpu core and the memory system. Each side gets a request/acknowledge handshake; the arbiter sequences one bus transaction at a time, returns read data and flags bus timeouts. Per-side stall generation is left to the core.

## Interface
- TIMEOUT_CYCLES, 255: max cycles a granted transaction waits for bus_ack before aborting; 0 disables timeout.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- if_req  in  1  fetch request; held high with stable if_addr until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction, valid while if_ack high.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_err  out  1  high with if_ack when the fetch timed out.
- dm_req  in  1  data request; held high with stable dm_rw/dm_addr/dm_wdata/dm_wstrb until dm_ack.
- dm_rw  in  1  0 = read, 1 = write.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_wstrb  in  4  byte write enables; ignored on reads.
- dm_rdata  out  32  read data, valid while dm_ack high; 0 on writes.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_err  out  1  high with dm_ack when the data access timed out.
- bus_req  out  1  request to memory; high until bus_ack sampled or timeout.
- bus_rw  out  1  0 = read, 1 = write.
- bus_addr  out  32  registered address.
- bus_wdata  out  32  registered write data.
- bus_wstrb  out  4  registered strobes; 0 for reads.
- bus_rdata  in  32  memory read data, valid with bus_ack.
- bus_ack  in  1  memory completion; ignored while bus_req low.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, IF_BUS, DM_BUS.
- IDLE: if any eligible request, grant and register the winner's address, rw, wdata and wstrb into the bus_* registers. Fetch forces bus_rw=0 and bus_wstrb=0.
- Eligibility: a requester whose ack is high in the current cycle is not eligible. This prevents a duplicate grant while its req is still high.
- Priority without MEM_ARB_RR_EN: dm beats if.
- IF_BUS/DM_BUS: bus_req high. On the edge bus_ack is sampled high:
  - capture bus_rdata into the granted side's rdata (dm_rdata=0 for writes);
  - pulse that side's ack for the following cycle;
  - return to IDLE.
- Timeout: an 8+ bit counter clears at grant and increments each bus-state cycle. On reaching TIMEOUT_CYCLES without ack:
  - drop bus_req;
  - pulse ack with err=1 and rdata=0;
  - return to IDLE.
- bus_ack in the same cycle the count reaches the limit counts as success.
- A requester that drops req before its ack is a protocol violation; the transaction still completes and its ack is still pulsed.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, last-grant = IF.
- Minimum latency: req sampled at edge 0 → bus_req high in cycle 1. If bus_ack is high in cycle 1, sampled at edge 1 → ack high in cycle 2. Request-to-ack is 2 cycles.
- Every transaction is followed by at least one IDLE (ack) cycle. Maximum throughput is one transaction per 2 cycles.
- Simultaneous if_req and dm_req in IDLE: one granted; the loser waits at least one full transaction.
- Reset mid-transaction: bus_req drops asynchronously and no ack is issued. Memory must tolerate the abandoned request.
- Error case: err is asserted only in the same cycle as ack.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. With both eligible in IDLE, grant the side not granted last; last-grant updates on every grant. Reset last-grant = IF, so dm wins the first contention.
- MEM_ARB_RR_EN undefined: fixed priority, dm always wins. Last-grant register is absent.

## Structure
- codes.v holds:
  - state encodings ARB_IDLE, ARB_IF_BUS, ARB_DM_BUS;
  - MEM_READ=0, MEM_WRITE=1, shared with mem_decoder's rw output.
- One sub-module, mem_arb_timer: loadable timeout counter with clear, enable and expired output; constant-expired-never when TIMEOUT_CYCLES=0.
- Everything else (FSM, muxes, capture registers) lives in mem_arbiter.

## Test plan
- Single fetch: if_addr=0x100, bus_ack in cycle 1 with bus_rdata=0x00000013 → if_ack in cycle 2, if_rdata=0x00000013, bus_addr=0x100, bus_rw=0.
- Single write: dm_addr=0x2000, dm_wdata=0xDEADBEEF, dm_wstrb=0xF, ack after 3 wait cycles → dm_ack with dm_rdata=0. Bus fields match throughout. busy high for 4 cycles.
- Contention: if_req and dm_req together. Fixed priority → dm served first, then if. With MEM_ARB_RR_EN over two contentions → dm, if, dm, if.
- Timeout: TIMEOUT_CYCLES=4, bus_ack never asserted → bus_req high exactly 4 cycles, then dm_ack with dm_err=1 and dm_rdata=0.
- Async reset asserted mid DM_BUS → bus_req, busy, acks and errs 0 immediately. After release, a new fetch completes normally.
- Back-to-back: dm_req held one extra cycle past dm_ack (ack cycle) → no duplicate grant; bus_req stays low in that cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, bus direction
// codes and the grant bookkeeping used by the optional round-robin policy.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_BUS = 2'd1,
        ARB_DM_BUS = 2'd2
    } arb_state_e;

    // Same encoding as the rw output of mem_decoder.
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

    function automatic logic rr_pick_dm(input logic if_elig, input logic dm_elig,
                                        input grant_e last_grant);
        return dm_elig && (!if_elig || last_grant == GRANT_IF);
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Timeout counter for a granted bus transaction: cleared at grant, counts while
// enabled, flags expiry on the cycle the count reaches TIMEOUT_CYCLES (0 = never).
module mem_arb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the cycles already spent, so the current cycle is the last allowed one.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            assign expired = enable && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data requesters onto one memory port, one transaction
// at a time. Define MEM_ARB_RR_EN for round-robin; otherwise data always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_rw,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy
);

    arb_state_e  state_q, state_d;
    logic        bus_rw_q, bus_rw_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        if_ack_q, if_ack_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        dm_ack_q, dm_ack_d;
    logic        dm_err_q, dm_err_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
`ifdef MEM_ARB_RR_EN
    grant_e      last_grant_q, last_grant_d;
`endif

    logic if_elig;
    logic dm_elig;
    logic grant_dm;
    logic timer_clear;
    logic timer_expired;

    // A side still acknowledging this cycle may have its req high; skip it.
    assign if_elig = if_req && !if_ack_q;
    assign dm_elig = dm_req && !dm_ack_q;

`ifdef MEM_ARB_RR_EN
    assign grant_dm = rr_pick_dm(if_elig, dm_elig, last_grant_q);
`else
    assign grant_dm = dm_elig;
`endif

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (state_q != ARB_IDLE),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        dm_ack_d    = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = '0;
        timer_clear = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (if_elig || dm_elig) begin
                    timer_clear = 1'b1;
                    if (grant_dm) begin
                        state_d     = ARB_DM_BUS;
                        bus_rw_d    = dm_rw;
                        bus_addr_d  = dm_addr;
                        bus_wdata_d = dm_wdata;
                        bus_wstrb_d = (dm_rw == MEM_WRITE) ? dm_wstrb : 4'h0;
`ifdef MEM_ARB_RR_EN
                        last_grant_d = GRANT_DM;
`endif
                    end else begin
                        state_d     = ARB_IF_BUS;
                        bus_rw_d    = MEM_READ;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_wstrb_d = 4'h0;
`ifdef MEM_ARB_RR_EN
                        last_grant_d = GRANT_IF;
`endif
                    end
                end
            end
            // An ack on the final allowed cycle beats the timeout.
            ARB_IF_BUS: begin
                if (bus_ack) begin
                    state_d    = ARB_IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus_rdata;
                end else if (timer_expired) begin
                    state_d  = ARB_IDLE;
                    if_ack_d = 1'b1;
                    if_err_d = 1'b1;
                end
            end
            ARB_DM_BUS: begin
                if (bus_ack) begin
                    state_d    = ARB_IDLE;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = (bus_rw_q == MEM_WRITE) ? 32'h0 : bus_rdata;
                end else if (timer_expired) begin
                    state_d  = ARB_IDLE;
                    dm_ack_d = 1'b1;
                    dm_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GRANT_IF;
`endif
        end else begin
            state_q     <= state_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_ack_q    <= dm_ack_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus_req   = (state_q != ARB_IDLE);
    assign busy      = (state_q != ARB_IDLE);
    assign bus_rw    = bus_rw_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
